// File: rtl/mainfsm_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encodings,
// opcodes, aluop classes, ALU/PC select codes and the decoded control word.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_IWB     = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12,
    S_ANDIEX  = 4'd13,
    S_ORIEX   = 4'd14,
    S_SLTIEX  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_BEQ   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_BNE   = 3'b011;
  localparam logic [2:0] ALUOP_ORI   = 3'b100;
  localparam logic [2:0] ALUOP_ANDI  = 3'b101;
  localparam logic [2:0] ALUOP_SLTI  = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control word, before memory-ready and reset gating.
  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immzext;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       branch;
    logic       branchne;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: op_legal = 1'b1;
      default:                                 op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_state(input state_t s);
    is_mem_state = (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mainfsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave):
// opcode/flags in, select and strobe lines out.
interface mainfsm_if;
  logic [5:0]             op;
  logic                   zero;
  logic                   mem_ready;
  logic                   pcen;
  logic                   memwrite;
  logic                   irwrite;
  logic                   regwrite;
  logic                   iord;
  logic                   alusrca;
  logic [1:0]             alusrcb;
  logic                   immzext;
  logic                   regdst;
  logic                   memtoreg;
  logic [1:0]             pcsrc;
  logic [2:0]             aluop;
  logic                   instr_done;
  logic                   illegal_op;
  mainfsm_pkg::state_t    state;

  modport master (
    input  op, zero, mem_ready,
    output pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
           immzext, regdst, memtoreg, pcsrc, aluop, instr_done,
           illegal_op, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
           immzext, regdst, memtoreg, pcsrc, aluop, instr_done,
           illegal_op, state
  );
endinterface

// File: rtl/mainfsm_outdec.sv
// Combinational state-to-control-word decoder for the main FSM.
// Memory-ready and reset gating are applied by the caller.
module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  state_t state,
  output ctrl_t  cw
);

  always_comb begin
    // NOTE: default every field first so no state path can infer a latch.
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.alusrcb = SRCB_FOUR;
        cw.aluop   = ALUOP_ADD;
        cw.pcsrc   = PCSRC_ALU;
        cw.irwrite = 1'b1;
        cw.pcwrite = 1'b1;
      end
      S_DECODE: begin
        cw.alusrcb = SRCB_IMMSH;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMRD: cw.iord = 1'b1;
      S_MEMWB: begin
        cw.memtoreg   = 1'b1;
        cw.regwrite   = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_MEMWR: begin
        cw.iord       = 1'b1;
        cw.memwrite   = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_RTYPEEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_B;
        cw.aluop   = ALUOP_RTYPE;
      end
      S_RTYPEWB: begin
        cw.regdst     = 1'b1;
        cw.regwrite   = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_BEQEX: begin
        cw.alusrca    = 1'b1;
        cw.alusrcb    = SRCB_B;
        cw.pcsrc      = PCSRC_ALUOUT;
        cw.aluop      = ALUOP_BEQ;
        cw.branch     = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_BNEEX: begin
        cw.alusrca    = 1'b1;
        cw.alusrcb    = SRCB_B;
        cw.pcsrc      = PCSRC_ALUOUT;
        cw.aluop      = ALUOP_BNE;
        cw.branchne   = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      S_ANDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ANDI;
        cw.immzext = 1'b1;
      end
      S_ORIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ORI;
        cw.immzext = 1'b1;
      end
      S_SLTIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_SLTI;
      end
      S_IWB: begin
        cw.regwrite   = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_JEX: begin
        cw.pcsrc      = PCSRC_JUMP;
        cw.pcwrite    = 1'b1;
        cw.instr_done = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic,
// memory-ready gating and PC enable. Define MAINFSM_MEMWAIT_EN to honour
// mem_ready; otherwise memory is treated as single-cycle.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mainfsm_if.master bus
);

  state_t state_q, state_d;
  ctrl_t  cw;
  logic   mem_ok;
  logic   gate_ok;
  logic   illegal;
  logic   pcwrite_g;

`ifdef MAINFSM_MEMWAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok           = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ANDI:      state_d = S_ANDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_SLTI:      state_d = S_SLTIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX, S_ANDIEX, S_ORIEX, S_SLTIEX: state_d = S_IWB;
      default:   state_d = S_FETCH;
    endcase
  end

  mainfsm_outdec u_outdec (
    .state (state_q),
    .cw    (cw)
  );

  // Strobes in the memory-access states wait for the memory; elsewhere they
  // pass straight through.
  assign gate_ok   = mem_ok | ~is_mem_state(state_q);
  assign illegal   = (state_q == S_DECODE) && !op_legal(bus.op);
  assign pcwrite_g = cw.pcwrite & gate_ok;

  // Every output is forced low while reset is held so an aborted access
  // cannot leave a write strobe on the bus.
  assign bus.pcen       = reset & (pcwrite_g | (cw.branch & bus.zero)
                                             | (cw.branchne & ~bus.zero));
  assign bus.memwrite   = reset & cw.memwrite;
  assign bus.irwrite    = reset & cw.irwrite & gate_ok;
  assign bus.regwrite   = reset & cw.regwrite;
  assign bus.iord       = reset & cw.iord;
  assign bus.alusrca    = reset & cw.alusrca;
  assign bus.alusrcb    = reset ? cw.alusrcb : 2'b00;
  assign bus.immzext    = reset & cw.immzext;
  assign bus.regdst     = reset & cw.regdst;
  assign bus.memtoreg   = reset & cw.memtoreg;
  assign bus.pcsrc      = reset ? cw.pcsrc : 2'b00;
  assign bus.aluop      = reset ? cw.aluop : 3'b000;
  assign bus.instr_done = reset & ((cw.instr_done & gate_ok) | illegal);
  assign bus.illegal_op = reset & illegal;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mainfsm.sv
// Scoreboard bench for mainfsm: stimulus pushes a per-instruction expectation
// derived from the instruction-level rules; a monitor checks at instr_done.
module tb_mainfsm;
  import mainfsm_pkg::*;

`ifdef MAINFSM_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  mainfsm_if bus ();

  mainfsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    int         cycles;
    int         irwrites;
    int         regwrites;
    int         memwrites;
    int         pcens;
    int         memtoregs;
    int         illegals;
    bit         has_exec;
    logic [8:0] exec_sig;
    bit         has_wb;
    logic [1:0] wb_sig;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [17:0] all_outs();
    return {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord,
            bus.alusrca, bus.alusrcb, bus.immzext, bus.regdst, bus.memtoreg,
            bus.pcsrc, bus.aluop, bus.instr_done, bus.illegal_op};
  endfunction

  // Reference: instruction-level latency, strobe counts and execute-cycle
  // signature {aluop, alusrca, alusrcb, immzext, pcsrc}.
  function automatic exp_t build_exp(input logic [5:0] op, input logic z,
                                     input int wf, input int wm);
    exp_t e;
    bit lw, sw, rt, beq, bne, j, addi, andi, ori, slti, imm, ill;
    lw   = (op == 6'b100011); sw  = (op == 6'b101011);
    rt   = (op == 6'b000000); beq = (op == 6'b000100);
    bne  = (op == 6'b000101); j   = (op == 6'b000010);
    addi = (op == 6'b001000); andi = (op == 6'b001100);
    ori  = (op == 6'b001101); slti = (op == 6'b001010);
    imm  = addi || andi || ori || slti;
    ill  = !(lw || sw || rt || beq || bne || j || imm);
    e.op = op;
    e.cycles = lw ? 5 : (sw || rt || imm) ? 4 : (beq || bne || j) ? 3 : 2;
    if (MEMWAIT) begin
      e.cycles += wf;
      if (lw || sw) e.cycles += wm;
    end
    e.irwrites  = 1;
    e.regwrites = (lw || rt || imm) ? 1 : 0;
    e.memwrites = sw ? (1 + (MEMWAIT ? wm : 0)) : 0;
    e.pcens     = 1 + ((beq && z) ? 1 : 0) + ((bne && !z) ? 1 : 0) + (j ? 1 : 0);
    e.memtoregs = lw ? 1 : 0;
    e.illegals  = ill ? 1 : 0;
    e.has_exec  = !ill;
    e.exec_sig  = 9'b0;
    if (lw || sw || addi) e.exec_sig = {3'b000, 1'b1, 2'b10, 1'b0, 2'b00};
    if (rt)               e.exec_sig = {3'b010, 1'b1, 2'b00, 1'b0, 2'b00};
    if (beq)              e.exec_sig = {3'b001, 1'b1, 2'b00, 1'b0, 2'b01};
    if (bne)              e.exec_sig = {3'b011, 1'b1, 2'b00, 1'b0, 2'b01};
    if (andi)             e.exec_sig = {3'b101, 1'b1, 2'b10, 1'b1, 2'b00};
    if (ori)              e.exec_sig = {3'b100, 1'b1, 2'b10, 1'b1, 2'b00};
    if (slti)             e.exec_sig = {3'b111, 1'b1, 2'b10, 1'b0, 2'b00};
    if (j)                e.exec_sig = {3'b000, 1'b0, 2'b00, 1'b0, 2'b10};
    e.has_wb = (e.regwrites != 0);
    e.wb_sig = lw ? 2'b01 : rt ? 2'b10 : 2'b00;
    return e;
  endfunction

  // Drives one instruction for exactly its expected length. mem_ready is low
  // for wf fetch cycles and wm memory-access cycles, random where irrelevant.
  task automatic run_instr(input logic [5:0] op, input logic z,
                           input int wf, input int wm);
    exp_t e;
    bit   mem;
    e   = build_exp(op, z, wf, wm);
    mem = (op == 6'b100011) || (op == 6'b101011);
    sbq.push_back(e);
    for (int k = 0; k < e.cycles; k++) begin
      bus.op   = op;
      bus.zero = z;
      if (k < wf)                                    bus.mem_ready = 1'b0;
      else if (k == wf)                              bus.mem_ready = 1'b1;
      else if (mem && k >= wf + 3 && k < wf + 3 + wm) bus.mem_ready = 1'b0;
      else if (mem && k == wf + 3 + wm)              bus.mem_ready = 1'b1;
      else                                           bus.mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor accumulators
  int         a_cyc, a_ir, a_rw, a_mw, a_pc, a_m2r, a_ill, since_ir;
  bit         exec_seen, wb_seen;
  logic [8:0] exec_sig;
  logic [1:0] wb_sig;

  task automatic clear_acc();
    a_cyc = 0; a_ir = 0; a_rw = 0; a_mw = 0; a_pc = 0; a_m2r = 0; a_ill = 0;
    since_ir = -10; exec_seen = 0; wb_seen = 0; exec_sig = '0; wb_sig = '0;
  endtask

  initial begin
    exp_t e;
    clear_acc();
    forever begin
      @(negedge clk);
      if (!reset) begin
        clear_acc();
      end else begin
        a_cyc++;
        if (bus.irwrite)    a_ir++;
        if (bus.regwrite)   a_rw++;
        if (bus.memwrite)   a_mw++;
        if (bus.pcen)       a_pc++;
        if (bus.memtoreg)   a_m2r++;
        if (bus.illegal_op) a_ill++;
        if (bus.irwrite)          since_ir = 0;
        else if (since_ir >= 0)   since_ir++;
        if (since_ir == 2 && !exec_seen) begin
          exec_seen = 1'b1;
          exec_sig  = {bus.aluop, bus.alusrca, bus.alusrcb, bus.immzext, bus.pcsrc};
        end
        if (bus.regwrite) begin
          wb_seen = 1'b1;
          wb_sig  = {bus.regdst, bus.memtoreg};
        end
        if (bus.instr_done) begin
          check("sb_depth", sbq.size(), 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("cycles op=%b", e.op), a_cyc, e.cycles);
            check($sformatf("irwrite op=%b", e.op), a_ir, e.irwrites);
            check($sformatf("regwrite op=%b", e.op), a_rw, e.regwrites);
            check($sformatf("memwrite op=%b", e.op), a_mw, e.memwrites);
            check($sformatf("pcen op=%b", e.op), a_pc, e.pcens);
            check($sformatf("memtoreg op=%b", e.op), a_m2r, e.memtoregs);
            check($sformatf("illegal op=%b", e.op), a_ill, e.illegals);
            if (e.has_exec) begin
              check($sformatf("exec_seen op=%b", e.op), exec_seen, 1);
              check($sformatf("exec_sig op=%b", e.op), exec_sig, e.exec_sig);
            end
            if (e.has_wb) begin
              check($sformatf("wb_seen op=%b", e.op), wb_seen, 1);
              check($sformatf("wb_sig op=%b", e.op), wb_sig, e.wb_sig);
            end
          end
          clear_acc();
        end else if (a_cyc > 64) begin
          check("instr_timeout", a_cyc, 64);
          clear_acc();
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rt_states [4];
    logic [5:0] legal_ops [10];
    logic [5:0] op;
    rt_states = '{4'd0, 4'd1, 4'd6, 4'd7};
    legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J};

    reset = 1'b0;
    bus.op = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", bus.state, 0);
    check("reset_outputs", all_outs(), 0);
    reset = 1'b1;

    // R-type straight out of reset: state walk and FETCH/RTYPEWB controls.
    fork
      run_instr(OP_RTYPE, 1'b0, 0, 0);
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check($sformatf("rtype_state%0d", k), bus.state, rt_states[k]);
          if (k == 0)
            check("fetch_ir_pc_srcb", {bus.irwrite, bus.pcen, bus.alusrcb}, 4'b1101);
          if (k == 3)
            check("rtypewb_rw_rd", {bus.regwrite, bus.regdst}, 2'b11);
        end
      end
    join

    run_instr(OP_LW,   1'b0, 0, 3);
    run_instr(OP_BEQ,  1'b1, 0, 0);
    run_instr(OP_BEQ,  1'b0, 0, 0);
    run_instr(OP_BNE,  1'b1, 0, 0);
    run_instr(OP_BNE,  1'b0, 0, 0);
    run_instr(OP_ANDI, 1'b0, 0, 0);
    run_instr(6'b111111, 1'b0, 0, 0);
    run_instr(OP_SW,   1'b0, 2, 2);

    // Abort a store in MEMWR with memory not ready.
    bus.op = OP_SW; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    #2;
    check("abort_pre_state", bus.state, 5);
    check("abort_pre_memwrite", bus.memwrite, 1);
    reset = 1'b0;
    #1;
    check("abort_state", bus.state, 0);
    check("abort_outputs", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(OP_RTYPE, 1'b0, 0, 0);

    repeat (300) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      else                           op = legal_ops[$urandom_range(0, 9)];
      run_instr(op, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    repeat (2) @(posedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mainfsm.md
# mainfsm

Multicycle MIPS control unit. It sequences the shared datapath (PC, instruction/data memory port, register file, single ALU) through fetch, decode, execute, memory and writeback states. Per cycle it drives all datapath select and strobe lines plus the 3-bit `aluop` consumed by the team's ALU decoder. It sits beside `aludec` inside the controller, between the instruction register opcode field and the datapath.

## Interface
- No parameters; state and opcode encodings are fixed constants in the shared definitions file.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; while low, state = FETCH and all strobes are 0.
- `op` in 6: opcode field from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcen` out 1: PC write enable = `pcwrite | (branch & zero) | (branchne & ~zero)`.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register load.
- `regwrite` out 1: register file write.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `alusrca` out 1: ALU A select; 0 = PC, 1 = A register.
- `alusrcb` out 2: ALU B select; 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- `immzext` out 1: immediate is zero-extended, not sign-extended.
- `regdst` out 1: write register select; 1 = rd, 0 = rt.
- `memtoreg` out 1: writeback data select; 1 = memory data, 0 = ALUOut.
- `pcsrc` out 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop` out 3: ALU operation class.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- The 4-bit state register resets to FETCH.
- Outputs are decoded from `state`. The memory-gated strobes `irwrite`, `pcwrite`, `memwrite` and `instr_done` also depend on `mem_ready`.
- Any output not listed for a state is 0.
- `aluop` codes: add = 000, beq = 001, rtype = 010, bne = 011, ori = 100, andi = 101, slti = 111.

States (encoding 0–15) with their outputs and transitions:
- FETCH: `iord` = 0, `alusrca` = 0, `alusrcb` = 01, `aluop` = 000, `pcsrc` = 00.
  - `irwrite` and `pcwrite` are asserted only when `mem_ready` = 1.
  - Go to DECODE when `mem_ready` = 1; otherwise stay in FETCH.
- DECODE: `alusrca` = 0, `alusrcb` = 11, `aluop` = 000 (branch target into ALUOut). Next state by `op`:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 → RTYPEEX.
  - 000100 → BEQEX; 000101 → BNEEX.
  - 001000 → ADDIEX; 001100 → ANDIEX; 001101 → ORIEX; 001010 → SLTIEX.
  - 000010 → JEX.
  - Any other opcode → FETCH, with `illegal_op` = 1 and `instr_done` = 1.
- MEMADR: `alusrca` = 1, `alusrcb` = 10, `aluop` = 000. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `iord` = 1. Go to MEMWB when `mem_ready` = 1; otherwise stay.
- MEMWB: `regdst` = 0, `memtoreg` = 1, `regwrite` = 1, `instr_done` = 1. Go to FETCH.
- MEMWR: `iord` = 1, `memwrite` = 1.
  - `memwrite` is held until `mem_ready` = 1; `instr_done` is asserted on that cycle.
  - Then go to FETCH.
- RTYPEEX: `alusrca` = 1, `alusrcb` = 00, `aluop` = 010. Go to RTYPEWB.
- RTYPEWB: `regdst` = 1, `regwrite` = 1, `instr_done` = 1. Go to FETCH.
- BEQEX / BNEEX: `alusrca` = 1, `alusrcb` = 00, `pcsrc` = 01, `instr_done` = 1. Go to FETCH.
  - BEQEX: `aluop` = 001, `branch` = 1.
  - BNEEX: `aluop` = 011, `branchne` = 1.
- Immediate execute states: `alusrca` = 1, `alusrcb` = 10. Each goes to IWB.
  - ADDIEX: `aluop` = 000.
  - ANDIEX: `aluop` = 101, `immzext` = 1.
  - ORIEX: `aluop` = 100, `immzext` = 1.
  - SLTIEX: `aluop` = 111.
- IWB: `regdst` = 0, `memtoreg` = 0, `regwrite` = 1, `instr_done` = 1. Go to FETCH.
- JEX: `pcsrc` = 10, `pcwrite` = 1, `instr_done` = 1. Go to FETCH.
- Unused encodings: go to FETCH with all outputs 0.

Boundary conditions:
- `reset` low mid-instruction: aborts immediately. No partial writes occur afterwards, because all strobes are 0 while `reset` is low.
- `mem_ready` held 0 stalls FETCH, MEMRD or MEMWR indefinitely. All non-strobe outputs stay stable during the stall.
- `op` is sampled only in DECODE and MEMADR.

## Timing
- Reset values: `state` = 0 (FETCH); every output 0; `pcen` = 0.
- Latency with zero wait states:
  - lw: 5 cycles.
  - sw, R-type, addi, andi, ori, slti: 4 cycles.
  - beq, bne, j: 3 cycles.
- Each `mem_ready` = 0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `pcen` is combinational from state and `zero`; the PC updates on the edge ending that cycle.

## Configuration
- `MAINFSM_MEMWAIT_EN` defined: `mem_ready` handshake honoured as described above.
- `MAINFSM_MEMWAIT_EN` undefined:
  - `mem_ready` is ignored and treated as constant 1, so memory is single-cycle.
  - The `mem_ready` port remains but is unused.
  - Latencies equal the zero-wait figures.

## Structure
- The shared definitions include file holds: the state encodings, opcode constants, `aluop` codes, and `alusrcb`/`pcsrc` select codes. `aludec` includes the same file.
- One natural sub-module: `mainfsm_outdec`, a combinational state-to-control-word decoder. `mainfsm` keeps the state register, next-state logic, `mem_ready` gating and `pcen`.

## Test plan
- Reset release with `op` = 000000 and `mem_ready` = 1:
  - FETCH has `irwrite` = `pcwrite` = 1, `alusrcb` = 01.
  - `state` then goes 0→1→6→7→0.
  - `regwrite` = 1 with `regdst` = 1 in RTYPEWB; `instr_done` pulses once.
- lw with `mem_ready` low 3 cycles in MEMRD: 8 total cycles; `memtoreg` = 1 and `regwrite` = 1 exactly one cycle.
- beq/bne with `zero` = 1 then 0:
  - beq gives `pcen` = 1 then 0.
  - bne gives `pcen` = 0 then 1.
  - `pcsrc` = 01 in both.
- andi `op` = 001100: ANDIEX has `aluop` = 101, `immzext` = 1; next cycle IWB has `regwrite` = 1, `regdst` = 0.
- `op` = 111111: `illegal_op` pulses in DECODE; next state is FETCH; no `regwrite` or `memwrite` ever asserted.
- `reset` pulled low during MEMWR with `mem_ready` = 0:
  - `memwrite` drops to 0 asynchronously and `state` = 0.
  - After release, a fetch begins.
